// File: rtl/button_led_ctrl_if.sv
// -----------------------------------------------------------------------------
// button_led_ctrl_if
// Bundles the per-channel button/LED signals of button_led_ctrl.
//   but   : raw asynchronous button levels, 1 = pressed (driven by master)
//   mode  : per-channel mode, 0 = follow, 1 = toggle (driven by master)
//   led   : LED drive, 1 = on (driven by slave)
//   press : one-cycle strobe per accepted debounced press (driven by slave)
// The controller itself connects through the slave modport.
// -----------------------------------------------------------------------------
interface button_led_ctrl_if #(
    parameter int CHANNELS = 4
);
    logic [CHANNELS-1:0] but;
    logic [CHANNELS-1:0] mode;
    logic [CHANNELS-1:0] led;
    logic [CHANNELS-1:0] press;

    modport master (
        output but,
        output mode,
        input  led,
        input  press
    );

    modport slave (
        input  but,
        input  mode,
        output led,
        output press
    );
endinterface

// File: rtl/button_led_ctrl.sv
// -----------------------------------------------------------------------------
// button_led_ctrl
// Multi-channel button-to-LED controller. Each channel synchronises its raw
// button through two flops, debounces the synchronised level with a counter
// that must see DEBOUNCE_CYCLES consecutive differing samples, and drives its
// LED either as a copy of the debounced level (follow) or from a toggle bit
// that flips on every accepted press (toggle).
// Ports:
//   clk : system clock, all state on the rising edge
//   rst : synchronous active-high reset
//   bus : button_led_ctrl_if slave modport (but, mode in; led, press out)
// -----------------------------------------------------------------------------
module button_led_ctrl #(
    parameter int CHANNELS        = 4,
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic                clk,
    input  logic                rst,
    button_led_ctrl_if.slave    bus
);
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [CHANNELS-1:0] s1_r;
    logic [CHANNELS-1:0] s2_r;
    logic [CHANNELS-1:0] stable_r;
    logic [CHANNELS-1:0] tog_r;
    logic [CHANNELS-1:0] press_r;
    logic [CNT_W-1:0]    cnt_r [CHANNELS];

    logic [CHANNELS-1:0] stable_s;
    logic [CHANNELS-1:0] tog_s;
    logic [CHANNELS-1:0] press_s;
    logic [CNT_W-1:0]    cnt_s [CHANNELS];

    // Two-flop synchroniser for the asynchronous button levels.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_r <= {CHANNELS{1'b0}};
            s2_r <= {CHANNELS{1'b0}};
        end else begin
            s1_r <= bus.but;
            s2_r <= s1_r;
        end
    end

    // Debounce next-state: count consecutive samples that differ from the
    // accepted level; any agreeing sample drops the count back to zero.
    always_comb begin
        stable_s = stable_r;
        tog_s    = tog_r;
        press_s  = {CHANNELS{1'b0}};
        for (int i = 0; i < CHANNELS; i++) begin
            cnt_s[i] = cnt_r[i];
            if (s2_r[i] == stable_r[i]) begin
                cnt_s[i] = CNT_ZERO;
            end else if (cnt_r[i] >= CNT_MAX) begin
                // Accept: the new level held long enough.
                cnt_s[i]    = CNT_ZERO;
                stable_s[i] = s2_r[i];
                if (s2_r[i]) begin
                    press_s[i] = 1'b1;
                    tog_s[i]   = ~tog_r[i];
                end else begin
                    press_s[i] = 1'b0;
                    tog_s[i]   = tog_r[i];
                end
            end else begin
                cnt_s[i] = cnt_r[i] + CNT_ONE;
            end
        end
    end

    // Debounce state, toggle state and press strobe registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            stable_r <= {CHANNELS{1'b0}};
            tog_r    <= {CHANNELS{1'b0}};
            press_r  <= {CHANNELS{1'b0}};
            for (int i = 0; i < CHANNELS; i++) begin
                cnt_r[i] <= CNT_ZERO;
            end
        end else begin
            stable_r <= stable_s;
            tog_r    <= tog_s;
            press_r  <= press_s;
            for (int i = 0; i < CHANNELS; i++) begin
                cnt_r[i] <= cnt_s[i];
            end
        end
    end

    // The LED is a plain 2:1 mux of registered state so a mode change shows
    // up immediately without disturbing the toggle or debounce state.
    assign bus.led   = (bus.mode & tog_r) | (~bus.mode & stable_r);
    assign bus.press = press_r;

endmodule

// File: tb/tb_button_led_ctrl.sv
// -----------------------------------------------------------------------------
// tb_button_led_ctrl
// Directed self-checking bench for button_led_ctrl with CHANNELS=4 and
// DEBOUNCE_CYCLES=4. Inputs change 1 time unit after a rising edge and
// outputs are sampled at the same point, so a level applied before edge 0
// is accepted at edge 5 (the 6th tick after it was applied).
// -----------------------------------------------------------------------------
module tb_button_led_ctrl;
    logic clk;
    logic rst;
    int   checks;
    int   failures;

    button_led_ctrl_if #(.CHANNELS(4)) bus ();

    button_led_ctrl #(
        .CHANNELS        (4),
        .DEBOUNCE_CYCLES (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst      = 1'b1;
        bus.but  = 4'hF;
        bus.mode = 4'hF;
        tick();
        tick();
        rst = 1'b0;
        checks++;
        if (bus.led !== 4'h0) begin
            failures++;
            $display("FAIL reset_led_toggle_mode: got %b expected %b", bus.led, 4'h0);
        end
        checks++;
        if (bus.press !== 4'h0) begin
            failures++;
            $display("FAIL reset_press: got %b expected %b", bus.press, 4'h0);
        end
        bus.mode = 4'h0;
        #1;
        checks++;
        if (bus.led !== 4'h0) begin
            failures++;
            $display("FAIL reset_led_follow_mode: got %b expected %b", bus.led, 4'h0);
        end
        for (int k = 1; k <= 5; k++) begin
            tick();
            checks++;
            if (bus.press !== 4'h0 || bus.led !== 4'h0) begin
                failures++;
                $display("FAIL reset_no_early_press tick %0d: got press=%b led=%b expected 0000/0000",
                         k, bus.press, bus.led);
            end
        end
        rst     = 1'b1;
        bus.but = 4'h0;
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_follow_clean();
        logic [3:0] exp_led;
        logic [3:0] exp_press;
        bus.mode = 4'h0;
        bus.but  = 4'b0001;
        for (int k = 1; k <= 10; k++) begin
            tick();
            exp_led   = (k >= 6) ? 4'b0001 : 4'b0000;
            exp_press = (k == 6) ? 4'b0001 : 4'b0000;
            checks++;
            if (bus.led !== exp_led || bus.press !== exp_press) begin
                failures++;
                $display("FAIL follow_press tick %0d: got led=%b press=%b expected led=%b press=%b",
                         k, bus.led, bus.press, exp_led, exp_press);
            end
        end
        bus.but = 4'b0000;
        for (int k = 1; k <= 8; k++) begin
            tick();
            exp_led = (k >= 6) ? 4'b0000 : 4'b0001;
            checks++;
            if (bus.led !== exp_led || bus.press !== 4'b0000) begin
                failures++;
                $display("FAIL follow_release tick %0d: got led=%b press=%b expected led=%b press=0000",
                         k, bus.led, bus.press, exp_led);
            end
        end
    endtask

    task automatic test_bounce();
        logic [11:0] seq;
        // Applied oldest first: 1,1,1,0,1,1,1 then zeros.
        seq = 12'b0000_0111_0111;
        for (int k = 0; k < 12; k++) begin
            bus.but = {2'b00, seq[k], 1'b0};
            tick();
            checks++;
            if (bus.led !== 4'b0000 || bus.press !== 4'b0000) begin
                failures++;
                $display("FAIL bounce_reject step %0d: got led=%b press=%b expected 0000/0000",
                         k, bus.led, bus.press);
            end
        end
    endtask

    task automatic test_toggle();
        logic       tog_exp;
        logic       tog_next;
        int         strobes;
        logic [3:0] exp_press;
        tog_exp  = 1'b0;
        strobes  = 0;
        bus.mode = 4'b0100;
        for (int p = 0; p < 3; p++) begin
            tog_next = ~tog_exp;
            bus.but  = 4'b0100;
            for (int k = 1; k <= 8; k++) begin
                tick();
                if (bus.press[2] === 1'b1) strobes++;
                exp_press = (k == 6) ? 4'b0100 : 4'b0000;
                checks++;
                if (bus.led !== {1'b0, ((k >= 6) ? tog_next : tog_exp), 2'b00} ||
                    bus.press !== exp_press) begin
                    failures++;
                    $display("FAIL toggle_press %0d tick %0d: got led=%b press=%b expected led[2]=%b press=%b",
                             p, k, bus.led, bus.press, ((k >= 6) ? tog_next : tog_exp), exp_press);
                end
            end
            tog_exp = tog_next;
            bus.but = 4'b0000;
            for (int k = 1; k <= 7; k++) begin
                tick();
                if (bus.press[2] === 1'b1) strobes++;
                checks++;
                if (bus.led !== {1'b0, tog_exp, 2'b00} || bus.press !== 4'b0000) begin
                    failures++;
                    $display("FAIL toggle_release %0d tick %0d: got led=%b press=%b expected led[2]=%b press=0000",
                             p, k, bus.led, bus.press, tog_exp);
                end
            end
        end
        checks++;
        if (strobes !== 3) begin
            failures++;
            $display("FAIL toggle_strobe_count: got %0d expected 3", strobes);
        end
    endtask

    task automatic test_mode_switch();
        // tog[0]=1 (follow-mode press), tog[2]=1 (three toggles), all released.
        bus.mode = 4'b0000;
        #1;
        checks++;
        if (bus.led !== 4'b0000) begin
            failures++;
            $display("FAIL mode_to_follow: got %b expected %b", bus.led, 4'b0000);
        end
        bus.mode = 4'b0100;
        #1;
        checks++;
        if (bus.led !== 4'b0100) begin
            failures++;
            $display("FAIL mode_back_to_toggle: got %b expected %b", bus.led, 4'b0100);
        end
        bus.mode = 4'b0101;
        #1;
        checks++;
        if (bus.led !== 4'b0101) begin
            failures++;
            $display("FAIL mode_tog_kept_in_follow: got %b expected %b", bus.led, 4'b0101);
        end
        bus.mode = 4'b0000;
        tick();
    endtask

    task automatic test_simultaneous();
        logic [3:0] exp_led;
        logic [3:0] exp_press;
        bus.mode = 4'h0;
        bus.but  = 4'hF;
        for (int k = 1; k <= 8; k++) begin
            tick();
            exp_led   = (k >= 6) ? 4'hF : 4'h0;
            exp_press = (k == 6) ? 4'hF : 4'h0;
            checks++;
            if (bus.led !== exp_led || bus.press !== exp_press) begin
                failures++;
                $display("FAIL simultaneous tick %0d: got led=%b press=%b expected led=%b press=%b",
                         k, bus.led, bus.press, exp_led, exp_press);
            end
        end
        // tog was 0101 before; every channel flipped once.
        bus.mode = 4'hF;
        #1;
        checks++;
        if (bus.led !== 4'b1010) begin
            failures++;
            $display("FAIL simultaneous_toggle_state: got %b expected %b", bus.led, 4'b1010);
        end
        bus.mode = 4'h0;
        bus.but  = 4'h0;
        for (int k = 1; k <= 7; k++) tick();
        checks++;
        if (bus.led !== 4'h0 || bus.press !== 4'h0) begin
            failures++;
            $display("FAIL simultaneous_release: got led=%b press=%b expected 0000/0000",
                     bus.led, bus.press);
        end
    endtask

    task automatic test_reset_mid();
        logic [3:0] exp_led;
        logic [3:0] exp_press;
        bus.mode = 4'h0;
        bus.but  = 4'b1000;
        // After 4 edges the channel-3 counter holds 2.
        for (int k = 1; k <= 4; k++) begin
            tick();
            checks++;
            if (bus.press !== 4'h0) begin
                failures++;
                $display("FAIL reset_mid_pre tick %0d: got press=%b expected 0000", k, bus.press);
            end
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.mode = 4'hF;
        #1;
        checks++;
        if (bus.led !== 4'h0 || bus.press !== 4'h0) begin
            failures++;
            $display("FAIL reset_mid_clear: got led=%b press=%b expected 0000/0000",
                     bus.led, bus.press);
        end
        bus.mode = 4'h0;
        for (int k = 1; k <= 7; k++) begin
            tick();
            exp_led   = (k >= 6) ? 4'b1000 : 4'b0000;
            exp_press = (k == 6) ? 4'b1000 : 4'b0000;
            checks++;
            if (bus.led !== exp_led || bus.press !== exp_press) begin
                failures++;
                $display("FAIL reset_mid_accept tick %0d: got led=%b press=%b expected led=%b press=%b",
                         k, bus.led, bus.press, exp_led, exp_press);
            end
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        bus.but  = 4'h0;
        bus.mode = 4'h0;
        test_reset();
        test_follow_clean();
        test_bounce();
        test_toggle();
        test_mode_switch();
        test_simultaneous();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
